alu_addsub_seq: RTL and testbench
=================================

# alu_addsub_seq

Parametrised, multi-cycle add/subtract unit with valid/ready handshakes and registered status flags. It supersedes the combinational add/sub ALU, which has fixed 32-bit operands. Operands are processed in CHUNK-bit slices, one slice per clock, through a carry register, which trades latency for a short carry chain. It sits between the operand-fetch stage and the flag/writeback stage of the datapath.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of CHUNK.
- CHUNK, 8, slice width per cycle; NCHUNK = WIDTH/CHUNK.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operand/opcode valid.
- in_ready  out  1  unit can accept an operation.
- in0  in  WIDTH  operand A, two's complement.
- in1  in  WIDTH  operand B, two's complement.
- op1  in  4  opcode: 0000 add, 0001 add1, 0010 sub, 0011 sub1, others illegal.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts result.
- out  out  WIDTH  result.
- carryout  out  1  carry out of MSB.
- overflow  out  1  signed overflow.
- zero  out  1  out == 0.
- N  out  1  out[WIDTH-1].
- err  out  1  illegal opcode was issued.

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture operands and go to CALC (legal op) or DONE (illegal op).
  - CALC: one slice per cycle; slice counter runs 0..NCHUNK-1; after the last slice go to DONE.
  - DONE: out_valid=1; hold until out_ready=1, then go to IDLE.
- Operand capture: a = in0; b_eff and cin are set by opcode:
  - add: b_eff = in1, cin = 0.
  - add1: b_eff = 1, cin = 0.
  - sub: b_eff = ~in1, cin = 1.
  - sub1: b_eff = ~1, cin = 1.
- Per CALC cycle k: {c, sum[k*CHUNK +: CHUNK]} = a[slice k] + b_eff[slice k] + c. The carry register c is loaded with cin at capture.
- Flags are computed at entry to DONE:
  - carryout = final c. For sub/sub1, 1 means no borrow (unsigned in0 >= subtrahend).
  - overflow = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
  - zero = (out == 0); N = out[MSB].
- Illegal opcode: no CALC; out = 0, all flags 0, err = 1.
- Legal opcode: err = 0.
- out and all flags hold stable for the whole of DONE. They keep their last value in IDLE and CALC.
- in_ready is 0 in CALC and DONE. No new operation is accepted in the cycle a result is consumed.

## Timing
- Reset values:
  - state = IDLE, so in_ready = 1.
  - out_valid, out, carryout, overflow, zero, N and err are all 0.
- Latency, legal op: accept edge E; slices computed on edges E+1..E+NCHUNK; out_valid high after edge E+NCHUNK (4 cycles at defaults).
- Latency, illegal op: out_valid high after edge E+1.
- Throughput: the result handshake edge returns to IDLE. The next accept is possible on the following edge, giving NCHUNK+2 cycles per op minimum.
- in_valid while in_ready=0 is ignored; the source must hold it.
- out_ready while out_valid=0 has no effect.
- rst_n low at any point, including mid-CALC or in DONE, immediately aborts the operation and forces all reset values. No partial result is ever presented.

## Configuration
- ALU_SAT_EN defined: on overflow, out saturates to 0111…1 if a[MSB]=0, or to 1000…0 if a[MSB]=1.
  - overflow is still reported as 1.
  - carryout is the raw carry.
  - zero and N are computed from the saturated out.
- ALU_SAT_EN undefined: results wrap modulo 2^WIDTH.

## Test plan
- add 0x7FFFFFFF + 0x00000001:
  - Without ALU_SAT_EN: out=0x80000000, overflow=1, N=1, carryout=0, zero=0, out_valid 4 cycles after accept.
  - With ALU_SAT_EN: out=0x7FFFFFFF, N=0, overflow=1.
- sub 0x00000005 − 0x00000005 -> out=0, zero=1, carryout=1, overflow=0, N=0.
- sub1 0x00000000 -> out=0xFFFFFFFF, N=1, carryout=0, overflow=0. add1 0xFFFFFFFF -> out=0, carryout=1, zero=1, overflow=0 (carry propagates across all 4 slices).
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - out and flags stay constant, in_ready stays 0, a second in_valid is not accepted.
  - On out_ready=1, out_valid drops and in_ready rises the next cycle.
- op1=0111 with in0=0x12345678 -> out_valid 1 cycle after accept, out=0, err=1, all flags 0. The following legal add clears err.
- Assert rst_n=0 on the second CALC cycle -> in_ready=1 and all outputs 0 immediately. A new add after release yields the correct result with no stale carry.

Source files
------------

// File: rtl/alu_addsub_seq_if.sv
// alu_addsub_seq_if: operand/opcode request and result/flag response bundle for alu_addsub_seq.
interface alu_addsub_seq_if #(parameter int WIDTH = 32);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in0;
   logic [WIDTH-1:0] in1;
   logic [3:0]       op1;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             carryout;
   logic             overflow;
   logic             zero;
   logic             N;
   logic             err;
   modport master (
      output in_valid, in0, in1, op1, out_ready,
      input  in_ready, out_valid, out, carryout, overflow, zero, N, err
   );
   modport slave (
      input  in_valid, in0, in1, op1, out_ready,
      output in_ready, out_valid, out, carryout, overflow, zero, N, err
   );
endinterface

// File: rtl/alu_addsub_seq.sv
// alu_addsub_seq: multi-cycle add/sub, one CHUNK-bit slice per clock through a carry register.
// Define ALU_SAT_EN to saturate the result on signed overflow instead of wrapping.
module alu_addsub_seq #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input logic            clk,
   input logic            rst_n,
   alu_addsub_seq_if.slave bus
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int KW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t           state;
   logic [WIDTH-1:0] a, b, sum, sum_n, res, bop;
   logic             c, ov;
   logic [KW-1:0]    k;
   logic [CHUNK:0]   s;
   always_comb begin
      bop = bus.op1[0] ? WIDTH'(1) : bus.in1;
      s = {1'b0, a[k*CHUNK +: CHUNK]} + {1'b0, b[k*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, c};
      sum_n = sum;
      sum_n[k*CHUNK +: CHUNK] = s[CHUNK-1:0];
      ov = (a[WIDTH-1] == b[WIDTH-1]) && (sum_n[WIDTH-1] != a[WIDTH-1]);
`ifdef ALU_SAT_EN
      res = ov ? {a[WIDTH-1], {(WIDTH-1){~a[WIDTH-1]}}} : sum_n;
`else
      res = sum_n;
`endif
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         bus.in_ready <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.out      <= '0;
         bus.carryout <= 1'b0;
         bus.overflow <= 1'b0;
         bus.zero     <= 1'b0;
         bus.N        <= 1'b0;
         bus.err      <= 1'b0;
         a            <= '0;
         b            <= '0;
         sum          <= '0;
         c            <= 1'b0;
         k            <= '0;
      end else begin
         unique case (state)
            IDLE: if (bus.in_valid) begin
               a            <= bus.in0;
               bus.in_ready <= 1'b0;
               if (bus.op1[3:2] == 2'b00) begin
                  b     <= bus.op1[1] ? ~bop : bop;
                  c     <= bus.op1[1];
                  k     <= '0;
                  state <= CALC;
               end else begin
                  // illegal op: clear results now, raise out_valid on the next edge
                  bus.out      <= '0;
                  bus.carryout <= 1'b0;
                  bus.overflow <= 1'b0;
                  bus.zero     <= 1'b0;
                  bus.N        <= 1'b0;
                  bus.err      <= 1'b1;
                  state        <= DONE;
               end
            end
            CALC: begin
               sum <= sum_n;
               c   <= s[CHUNK];
               k   <= k + 1'b1;
               if (k == KW'(NCHUNK - 1)) begin
                  state         <= DONE;
                  bus.out_valid <= 1'b1;
                  bus.out       <= res;
                  bus.carryout  <= s[CHUNK];
                  bus.overflow  <= ov;
                  bus.zero      <= (res == '0);
                  bus.N         <= res[WIDTH-1];
                  bus.err       <= 1'b0;
               end
            end
            DONE: if (!bus.out_valid) begin
               bus.out_valid <= 1'b1;
            end else if (bus.out_ready) begin
               bus.out_valid <= 1'b0;
               bus.in_ready  <= 1'b1;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_addsub_seq.sv
// tb_alu_addsub_seq: directed vectors with hand-computed results for alu_addsub_seq.
// Expected values for the overflow case follow ALU_SAT_EN when it is defined.
module tb_alu_addsub_seq;
   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   lat;
   alu_addsub_seq_if #(.WIDTH(32)) bus ();
   alu_addsub_seq #(.WIDTH(32), .CHUNK(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   logic [4:0] fl;
   assign fl = {bus.carryout, bus.overflow, bus.zero, bus.N, bus.err};
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      bus.op1 = op;
      bus.in0 = x;
      bus.in1 = y;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask
   task automatic wait_valid(output int l);
      l = 0;
      while (!bus.out_valid && l < 20) begin
         @(negedge clk);
         l++;
      end
   endtask
   task automatic consume();
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask
   initial begin
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.in0 = '0;
      bus.in1 = '0;
      bus.op1 = '0;
      repeat (2) @(negedge clk);
      chk("reset_hs", {bus.in_ready, bus.out_valid}, 2'b10);
      chk("reset_out", {bus.out, fl}, {32'h0, 5'b00000});
      rst_n = 1'b1;
      @(negedge clk);
      issue(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001);
      wait_valid(lat);
      chk("add_ovf_lat", lat, 4);
`ifdef ALU_SAT_EN
      chk("add_ovf_out", bus.out, 32'h7FFF_FFFF);
      chk("add_ovf_flags", fl, 5'b01000);
`else
      chk("add_ovf_out", bus.out, 32'h8000_0000);
      chk("add_ovf_flags", fl, 5'b01010);
`endif
      consume();
      issue(4'b0010, 32'h5, 32'h5);
      wait_valid(lat);
      chk("sub_eq_out", bus.out, 32'h0);
      chk("sub_eq_flags", fl, 5'b10100);
      consume();
      issue(4'b0011, 32'h0, 32'hDEAD_BEEF);
      wait_valid(lat);
      chk("sub1_out", bus.out, 32'hFFFF_FFFF);
      chk("sub1_flags", fl, 5'b00010);
      consume();
      issue(4'b0001, 32'hFFFF_FFFF, 32'h1234_5678);
      wait_valid(lat);
      chk("add1_lat", lat, 4);
      chk("add1_out", bus.out, 32'h0);
      chk("add1_flags", fl, 5'b10100);
      consume();
      // backpressure with a competing request that must not be accepted
      issue(4'b0010, 32'hA, 32'h3);
      wait_valid(lat);
      bus.op1 = 4'b0000;
      bus.in0 = 32'h1;
      bus.in1 = 32'h1;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_hold", {bus.in_ready, bus.out_valid, bus.out, fl}, {1'b0, 1'b1, 32'h7, 5'b10000});
      end
      consume();
      chk("bp_release", {bus.in_ready, bus.out_valid, bus.out}, {1'b1, 1'b0, 32'h7});
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("bp_no_accept", {bus.in_ready, bus.out_valid}, 2'b10);
      issue(4'b0111, 32'h1234_5678, 32'h1);
      chk("ill_pre", bus.out_valid, 1'b0);
      wait_valid(lat);
      chk("ill_lat", lat, 1);
      chk("ill_res", {bus.out, fl}, {32'h0, 5'b00001});
      consume();
      issue(4'b0000, 32'h2, 32'h3);
      wait_valid(lat);
      chk("clr_err", {bus.out, fl}, {32'h5, 5'b00000});
      consume();
      issue(4'b0000, 32'hFFFF_FFFF, 32'h1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_hs", {bus.in_ready, bus.out_valid}, 2'b10);
      chk("abort_out", {bus.out, fl}, {32'h0, 5'b00000});
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(4'b0000, 32'h0000_00FF, 32'h1);
      wait_valid(lat);
      chk("post_rst_lat", lat, 4);
      chk("post_rst_res", {bus.out, fl}, {32'h100, 5'b00000});
      consume();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
